cc_controller: RTL and testbench
================================

Name: cc_controller

Overview:
- Condition-code control unit for the pipelined Y86-64 core; owns the 3-bit CC register {ZF,SF,OF}.
- Decides each cycle whether the E-stage ALU flags are committed.
- Blocks CC updates while an exception is in flight in M/W.
- Evaluates the jXX/cmovXX condition for the E-stage instruction.
- Sits between the ALU and the branch/cmov logic in execute.

Parameters:
CC_RESET, 3'b100, CC value after any reset, ordered {ZF,SF,OF}
CNT_W, 16, width of optional branch statistics counters

Ports:
clk  input  1  clock, rising edge
async_reset  input  1  reset, asynchronous, active-low
sync_clear  input  1  synchronous clear, active-high (pipeline restart/flush)
e_valid  input  1  E stage holds a real instruction, not a bubble
e_icode  input  4  E-stage icode
e_ifun  input  4  E-stage ifun
alu_zf  input  1  ALU zero flag for current E instruction
alu_sf  input  1  ALU sign flag
alu_of  input  1  ALU overflow flag
m_stat  input  3  status of M-stage instruction
w_stat  input  3  status of W-stage instruction
restart  input  1  single-cycle pulse that leaves FROZEN
cc_out  output  3  registered CC {ZF,SF,OF}
e_cnd  output  1  condition result for E instruction
cc_frozen  output  1  high while in FROZEN
br_total  output  CNT_W  jXX count (CC_STATS_EN only)
br_taken  output  CNT_W  taken jXX count (CC_STATS_EN only)

Behaviour:
- Encodings:
  - icode: OPq=6, jXX=7, cmovXX=2.
  - stat: BUB=0, AOK=1, HLT=2, ADR=3, INS=4.
  - BUB is treated as AOK.
- States: RUN, FROZEN. State register is 1 bit.
- Reset priority: async_reset low > sync_clear > normal operation.
- Async reset (low) forces immediately: cc_out=CC_RESET, state=RUN, cc_frozen=0, counters=0.
- sync_clear high: same values, applied on the next rising edge.
- exc = (m_stat not in {BUB,AOK}) or (w_stat not in {BUB,AOK}).
- set_cc = state==RUN & e_valid & e_icode==OPq & ~exc.
- On the edge where set_cc=1: cc_out <= {alu_zf,alu_sf,alu_of}. CC is visible 1 cycle after E.
- All other cycles: cc_out holds.
- Transitions:
  - RUN -> FROZEN on an edge with exc=1.
  - FROZEN -> RUN on an edge with restart=1 & exc=0.
  - restart and exc together: stays/enters FROZEN (exception wins).
  - restart while in RUN: ignored.
- cc_frozen = (state==FROZEN), registered.
- e_cnd is combinational from the registered cc_out (never the same-cycle ALU flags), per e_ifun:
  - 0: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: ~ZF
  - 5 ge: ~(SF^OF)
  - 6 g: ~(SF^OF)&~ZF
  - 7..15: 0
- e_cnd is computed regardless of icode; consumers qualify it.
- e_cnd remains valid in FROZEN and uses the frozen CC.
- Back-to-back OPq instructions: each edge commits that cycle's flags; the last one wins.
- OPq in E with exc=1 in the same cycle: not committed, and state goes FROZEN.

Optional Feature:
Macro: CC_STATS_EN
- Defined:
  - br_total increments on each edge with state==RUN & e_valid & e_icode==jXX.
  - br_taken increments on the same edges when e_cnd=1.
  - Both counters saturate at all-ones.
  - Both clear on async_reset or sync_clear.
- Undefined:
  - Ports br_total and br_taken are absent.
  - No counter logic is compiled.

Decomposition:
- Shared package y86_pkg holds:
  - ICODE_OPQ/ICODE_JXX/ICODE_CMOVXX
  - STAT_BUB/AOK/HLT/ADR/INS
  - condition ifun constants C_ALWAYS..C_G
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0
- One sub-module: cc_cond_eval, purely combinational (cc[2:0], ifun[3:0]) -> cnd.
  - Reused by the cmov/branch logic elsewhere.

Test Plan:
1. async_reset low mid-cycle, then high -> cc_out=3'b100 immediately, cc_frozen=0, e_cnd=1 for ifun=3 (e).
2. OPq, e_valid=1, flags Z=0 S=1 O=0, stat AOK -> cc_out=3'b010 next cycle; ifun=2 (l) gives e_cnd=1; ifun=6 (g) gives e_cnd=0.
3. OPq with flags 3'b001 while m_stat=ADR -> cc_out unchanged, cc_frozen=1 next cycle; a further OPq stays blocked; restart with stat AOK -> RUN; next OPq commits.
4. restart and w_stat=HLT in the same cycle -> stays FROZEN; sync_clear -> RUN, cc_out=3'b100.
5. OPq with e_valid=0 (bubble) -> no CC change. Sweep ifun 0..15 against all 8 CC values vs reference table; ifun>=7 gives e_cnd=0.
6. CC_STATS_EN, CNT_W=4: 20 jXX, 12 taken -> br_total=15 (saturated), br_taken=12; jXX during FROZEN not counted.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute-stage condition-code logic.
// Holds icode/stat/condition constants, CC bit positions and the CC FSM state type.
package y86_pkg;

    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } cc_state_t;

    // A bubble carries no exception, so it behaves like AOK.
    function automatic logic stat_is_exc(input logic [2:0] stat);
        return !((stat == STAT_BUB) || (stat == STAT_AOK));
    endfunction

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator: (cc {ZF,SF,OF}, ifun) -> cnd.
// Shared with the cmov/branch logic; undefined ifun values evaluate false.
module cc_cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic lt;

    assign zf = cc[CC_ZF];
    assign lt = cc[CC_SF] ^ cc[CC_OF];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_controller.sv
// Condition-code register and commit control for the Y86-64 execute stage.
// Optional branch statistics counters are compiled in when CC_STATS_EN is defined.
module cc_controller
    import y86_pkg::*;
#(
    parameter logic [2:0] CC_RESET = 3'b100,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             sync_clear,
    input  logic             e_valid,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       w_stat,
    input  logic             restart,
    output logic [2:0]       cc_out,
    output logic             e_cnd,
    output logic             cc_frozen
`ifdef CC_STATS_EN
    ,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
`endif
);

    cc_state_t  state_reg;
    cc_state_t  state_next;
    logic [2:0] cc_reg;
    logic       exc;
    logic       set_cc;

    assign exc = stat_is_exc(m_stat) || stat_is_exc(w_stat);

    always_comb begin
        state_next = state_reg;
        set_cc     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                // An exception in M/W blocks the same-cycle commit as well as freezing.
                set_cc = e_valid && (e_icode == ICODE_OPQ) && !exc;
                if (exc)
                    state_next = ST_FROZEN;
            end
            ST_FROZEN: begin
                if (restart && !exc)
                    state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_reg <= ST_RUN;
            cc_reg    <= CC_RESET;
        end else if (sync_clear) begin
            state_reg <= ST_RUN;
            cc_reg    <= CC_RESET;
        end else begin
            state_reg <= state_next;
            if (set_cc)
                cc_reg <= {alu_zf, alu_sf, alu_of};
        end
    end

    assign cc_out    = cc_reg;
    assign cc_frozen = (state_reg == ST_FROZEN);

    // Evaluated from the registered CC only, so it is never combinationally tied to the ALU.
    cc_cond_eval u_cond (
        .cc   (cc_reg),
        .ifun (e_ifun),
        .cnd  (e_cnd)
    );

`ifdef CC_STATS_EN
    logic [CNT_W-1:0] br_total_reg;
    logic [CNT_W-1:0] br_taken_reg;
    logic             br_seen;

    assign br_seen = (state_reg == ST_RUN) && e_valid && (e_icode == ICODE_JXX);

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            br_total_reg <= '0;
            br_taken_reg <= '0;
        end else if (sync_clear) begin
            br_total_reg <= '0;
            br_taken_reg <= '0;
        end else if (br_seen) begin
            if (br_total_reg != '1)
                br_total_reg <= br_total_reg + 1'b1;
            if (e_cnd && (br_taken_reg != '1))
                br_taken_reg <= br_taken_reg + 1'b1;
        end
    end

    assign br_total = br_total_reg;
    assign br_taken = br_taken_reg;
`endif

endmodule

// File: tb/tb_cc_controller.sv
// Self-checking bench for cc_controller: directed scenarios plus random traffic
// compared against a behavioural model of the CC register, freeze state and counters.
module tb_cc_controller;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                async_reset = 1'b0;
    logic                sync_clear = 1'b0;
    logic                e_valid = 1'b0;
    logic [3:0]          e_icode = 4'h0;
    logic [3:0]          e_ifun = 4'h0;
    logic                alu_zf = 1'b0;
    logic                alu_sf = 1'b0;
    logic                alu_of = 1'b0;
    logic [2:0]          m_stat = 3'd1;
    logic [2:0]          w_stat = 3'd1;
    logic                restart = 1'b0;
    logic [2:0]          cc_out;
    logic                e_cnd;
    logic                cc_frozen;
`ifdef CC_STATS_EN
    logic [TB_CNT_W-1:0] br_total;
    logic [TB_CNT_W-1:0] br_taken;
`endif

    cc_controller #(.CC_RESET(3'b100), .CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .sync_clear  (sync_clear),
        .e_valid     (e_valid),
        .e_icode     (e_icode),
        .e_ifun      (e_ifun),
        .alu_zf      (alu_zf),
        .alu_sf      (alu_sf),
        .alu_of      (alu_of),
        .m_stat      (m_stat),
        .w_stat      (w_stat),
        .restart     (restart),
        .cc_out      (cc_out),
        .e_cnd       (e_cnd),
        .cc_frozen   (cc_frozen)
`ifdef CC_STATS_EN
        ,
        .br_total    (br_total),
        .br_taken    (br_taken)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [2:0] m_cc = 3'b100;
    logic       m_frozen = 1'b0;
    int         m_total = 0;
    int         m_taken = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Condition table written directly from the jump semantics.
    function automatic logic ref_cnd(input logic [2:0] cc, input logic [3:0] fn);
        bit z, less;
        z = cc[2];
        less = (cc[1] != cc[0]);
        if (fn == 0) return 1'b1;
        if (fn == 1) return less || z;
        if (fn == 2) return less;
        if (fn == 3) return z;
        if (fn == 4) return !z;
        if (fn == 5) return !less;
        if (fn == 6) return !less && !z;
        return 1'b0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_cc"}, {29'd0, cc_out}, {29'd0, m_cc});
        check({tag, "_frz"}, {31'd0, cc_frozen}, {31'd0, m_frozen});
`ifdef CC_STATS_EN
        check({tag, "_tot"}, {28'd0, br_total}, m_total);
        check({tag, "_tkn"}, {28'd0, br_taken}, m_taken);
`endif
    endtask

    // One clock: drive inputs after negedge, check e_cnd, then check state after posedge.
    task automatic cycle(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [2:0] fl, input logic [2:0] ms, input logic [2:0] ws,
                         input logic rs, input logic sc);
        bit exc, cnd;
        @(negedge clk);
        e_valid = v; e_icode = ic; e_ifun = fn;
        {alu_zf, alu_sf, alu_of} = fl;
        m_stat = ms; w_stat = ws; restart = rs; sync_clear = sc;
        #1;
        cnd = ref_cnd(m_cc, fn);
        check("e_cnd", {31'd0, e_cnd}, {31'd0, cnd});
        exc = (ms > 3'd1) || (ws > 3'd1);
        @(posedge clk);
        if (sc) begin
            m_cc = 3'b100; m_frozen = 1'b0; m_total = 0; m_taken = 0;
        end else begin
            if (!m_frozen && v && ic == 4'd7) begin
                if (m_total < CNT_MAX) m_total++;
                if (cnd && m_taken < CNT_MAX) m_taken++;
            end
            if (!m_frozen && v && ic == 4'd6 && !exc) m_cc = fl;
            if (exc) m_frozen = 1'b1;
            else if (m_frozen && rs) m_frozen = 1'b0;
        end
        #1;
        check_state("cyc");
    endtask

    task automatic probe(input logic [3:0] fn, input logic exp, input string tag);
        e_ifun = fn;
        #1;
        check(tag, {31'd0, e_cnd}, {31'd0, exp});
    endtask

    initial begin
        // Reset state
        #12;
        check_state("rst");
        @(negedge clk);
        async_reset = 1'b1;

        // OPq commit of {Z=0,S=1,O=0}
        cycle(1, 4'd6, 4'd0, 3'b010, 3'd1, 3'd1, 0, 0);
        check("t2_cc", {29'd0, cc_out}, 32'h2);
        probe(4'd2, 1'b1, "t2_l");
        probe(4'd6, 1'b0, "t2_g");

        // Exception blocks commit and freezes; restart resumes
        cycle(1, 4'd6, 4'd0, 3'b001, 3'd3, 3'd1, 0, 0);
        check("t3_cc", {29'd0, cc_out}, 32'h2);
        check("t3_frz", {31'd0, cc_frozen}, 32'h1);
        cycle(1, 4'd6, 4'd0, 3'b001, 3'd1, 3'd1, 0, 0);
        check("t3_blk", {29'd0, cc_out}, 32'h2);
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd1, 3'd1, 1, 0);
        check("t3_run", {31'd0, cc_frozen}, 32'h0);
        cycle(1, 4'd6, 4'd0, 3'b001, 3'd1, 3'd1, 0, 0);
        check("t3_cmt", {29'd0, cc_out}, 32'h1);

        // Restart with simultaneous exception stays frozen; sync_clear recovers
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd0, 3'd2, 0, 0);
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd1, 3'd2, 1, 0);
        check("t4_frz", {31'd0, cc_frozen}, 32'h1);
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd1, 3'd2, 0, 1);
        check("t4_clr_cc", {29'd0, cc_out}, 32'h4);
        check("t4_clr_frz", {31'd0, cc_frozen}, 32'h0);

        // Bubble OPq has no effect; ifun sweep over all CC values
        cycle(0, 4'd6, 4'd0, 3'b011, 3'd1, 3'd1, 0, 0);
        check("t5_bub", {29'd0, cc_out}, 32'h4);
        for (int c = 0; c < 8; c++) begin
            cycle(1, 4'd6, 4'd0, c[2:0], 3'd0, 3'd1, 0, 0);
            for (int f = 0; f < 16; f++)
                probe(f[3:0], ref_cnd(c[2:0], f[3:0]), "t5_sweep");
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] ic;
            logic [2:0] ms, ws;
            case ($urandom_range(0, 3))
                0: ic = 4'd6;
                1: ic = 4'd7;
                2: ic = 4'd2;
                default: ic = 4'($urandom);
            endcase
            ms = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
            ws = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
            cycle(1'($urandom), ic, 4'($urandom), 3'($urandom), ms, ws,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
        end

        // Mid-cycle async reset from a non-reset CC value
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd1, 3'd1, 1, 0);
        cycle(1, 4'd6, 4'd0, 3'b010, 3'd1, 3'd1, 0, 0);
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd3, 3'd1, 0, 0);
        e_ifun = 4'd3;
        #2;
        async_reset = 1'b0;
        #1;
        m_cc = 3'b100; m_frozen = 1'b0; m_total = 0; m_taken = 0;
        check("t1_cc", {29'd0, cc_out}, 32'h4);
        check("t1_frz", {31'd0, cc_frozen}, 32'h0);
        check("t1_e", {31'd0, e_cnd}, 32'h1);
        @(negedge clk);
        async_reset = 1'b1;

`ifdef CC_STATS_EN
        // 20 jXX with 12 taken: total saturates, taken does not; frozen jXX ignored
        cycle(1, 4'd6, 4'd0, 3'b100, 3'd1, 3'd1, 0, 0);
        for (int j = 0; j < 20; j++)
            cycle(1, 4'd7, (j < 12) ? 4'd3 : 4'd4, 3'b000, 3'd1, 3'd1, 0, 0);
        check("t6_tot", {28'd0, br_total}, 32'd15);
        check("t6_tkn", {28'd0, br_taken}, 32'd12);
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd4, 3'd1, 0, 0);
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd1, 3'd1, 0, 1);
        cycle(0, 4'd0, 4'd0, 3'b000, 3'd4, 3'd1, 0, 0);
        for (int j = 0; j < 3; j++)
            cycle(1, 4'd7, 4'd0, 3'b000, 3'd1, 3'd1, 0, 0);
        check("t6_frz_tot", {28'd0, br_total}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
